// File: rtl/memory_access_stage.sv
// memory_access_stage: load/store unit between execute and writeback.
// One memory op in flight; upstream is stalled until it completes.
module memory_access_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic                  flush,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_pc,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic                  wb_rd_we,
    output logic [XLEN-1:0]       wb_rd_data,
    output logic                  misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, nextState;
    logic [XLEN-1:0] addrQ, pcQ, storeQ, shifted, loadData;
    logic [REG_ADDR_W-1:0] rdQ;
    logic [1:0] sizeQ;
    logic unsignedQ, writeQ, rdWeQ;
    logic isMem, badAlign, accept, memStart, misTrap, doneStore, doneLoad;
    assign isMem     = ex_mem_read | ex_mem_write;
    assign badAlign  = (ex_funct3[1:0] == 2'd3) ||
                       (ex_funct3[1:0] == 2'd1 && ex_alu_result[0]) ||
                       (ex_funct3[1:0] == 2'd2 && ex_alu_result[1:0] != 2'd0);
    assign accept    = (state == IDLE) && ex_valid && !flush;
    assign memStart  = accept && isMem && !badAlign;
    assign misTrap   = accept && isMem && badAlign;
    assign doneStore = (state == REQ) && dmem_ready && writeQ;
    assign doneLoad  = (state == WAIT) && dmem_rvalid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = memStart ? REQ : IDLE;
            REQ:     nextState = dmem_ready ? (writeQ ? IDLE : WAIT) : REQ;
            default: nextState = dmem_rvalid ? IDLE : WAIT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ     <= '0;
            pcQ       <= '0;
            storeQ    <= '0;
            rdQ       <= '0;
            sizeQ     <= '0;
            unsignedQ <= 1'b0;
            writeQ    <= 1'b0;
            rdWeQ     <= 1'b0;
        end else if (memStart) begin
            addrQ     <= ex_alu_result;
            pcQ       <= ex_pc;
            storeQ    <= ex_store_data;
            rdQ       <= ex_rd_addr;
            sizeQ     <= ex_funct3[1:0];
            unsignedQ <= ex_funct3[2];
            writeQ    <= ex_mem_write;
            rdWeQ     <= ex_rd_we;
        end
    end
    assign stall      = (state != IDLE);
    assign dmem_req   = (state == REQ);
    assign dmem_we    = (state == REQ) && writeQ;
    assign dmem_addr  = {addrQ[XLEN-1:2], 2'b00};
    assign dmem_be    = (sizeQ == 2'd0 ? 4'h1 : sizeQ == 2'd1 ? 4'h3 : 4'hF) << addrQ[1:0];
    assign dmem_wdata = sizeQ == 2'd0 ? {(XLEN/8){storeQ[7:0]}} :
                        sizeQ == 2'd1 ? {(XLEN/16){storeQ[15:0]}} : storeQ;
    // Lane-aligned read data: move the addressed byte/half down to bit 0, then extend.
    assign shifted    = dmem_rdata >> {addrQ[1:0], 3'b000};
    assign loadData   = sizeQ == 2'd0 ? {{(XLEN-8){~unsignedQ & shifted[7]}}, shifted[7:0]} :
                        sizeQ == 2'd1 ? {{(XLEN-16){~unsignedQ & shifted[15]}}, shifted[15:0]} : shifted;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_pc      <= '0;
            wb_rd_addr <= '0;
            wb_rd_we   <= 1'b0;
            wb_rd_data <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= misTrap;
            wb_valid   <= (accept && !isMem) || misTrap || doneStore || doneLoad;
            if (accept && !isMem) begin
                wb_pc      <= ex_pc;
                wb_rd_addr <= ex_rd_addr;
                wb_rd_we   <= ex_rd_we;
                wb_rd_data <= ex_alu_result;
            end else if (misTrap) begin
                wb_pc      <= ex_pc;
                wb_rd_addr <= ex_rd_addr;
                wb_rd_we   <= 1'b0;
                wb_rd_data <= ex_alu_result;
            end else if (doneStore) begin
                wb_pc      <= pcQ;
                wb_rd_addr <= rdQ;
                wb_rd_we   <= 1'b0;
            end else if (doneLoad) begin
                wb_pc      <= pcQ;
                wb_rd_addr <= rdQ;
                wb_rd_we   <= rdWeQ;
                wb_rd_data <= loadData;
            end
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed vectors with a writeback scoreboard.
module tb_memory_access_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_rd_we = 1'b0, flush = 1'b0;
    logic [31:0] ex_pc = '0, ex_alu_result = '0, ex_store_data = '0, dmem_rdata = '0;
    logic [2:0] ex_funct3 = '0;
    logic [4:0] ex_rd_addr = '0;
    logic dmem_ready = 1'b0, dmem_rvalid = 1'b0;
    logic stall, dmem_req, dmem_we, wb_valid, wb_rd_we, misaligned;
    logic [31:0] dmem_addr, dmem_wdata, wb_pc, wb_rd_data;
    logic [3:0] dmem_be;
    logic [4:0] wb_rd_addr;
    int compared = 0, mismatched = 0;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        chkData;
    } exp_t;
    exp_t sb[$];
    exp_t mon;
    always #5 clk = ~clk;
    memory_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .flush(flush),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data), .misaligned(misaligned)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
                mon = sb.pop_front();
                chk("wb_pc", wb_pc, mon.pc);
                chk("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, mon.rd});
                chk("wb_rd_we", {31'd0, wb_rd_we}, {31'd0, mon.we});
                if (mon.chkData) chk("wb_rd_data", wb_rd_data, mon.data);
            end
        end
    end
    task automatic issue(input logic [31:0] pc, alu, sd, input logic rd, wr, input logic [2:0] f3,
                         input logic [4:0] rda, input logic we, fl);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_pc = pc; ex_alu_result = alu; ex_store_data = sd;
        ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_rd_addr = rda; ex_rd_we = we; flush = fl;
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_alu_result = 32'hDEAD_BEEC; ex_store_data = 32'h5555_5555;
    endtask
    task automatic doLoad(input logic [31:0] pc, addr, input logic [2:0] f3, input logic [4:0] rda,
                          input logic [31:0] rdata, exp, input logic [3:0] be);
        sb.push_back('{pc, rda, 1'b1, exp, 1'b1});
        issue(pc, addr, 32'd0, 1'b1, 1'b0, f3, rda, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("ld_stall_req", {31'd0, stall}, 32'd1);
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("ld_be", {28'd0, dmem_be}, {28'd0, be});
        @(posedge clk); #1;
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        chk("ld_stall_wait", {31'd0, stall}, 32'd1);
        chk("ld_req_wait", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("ld_stall_done", {31'd0, stall}, 32'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_wb_data", wb_rd_data, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        // ALU op: one-cycle writeback, no stall
        sb.push_back('{32'h40, 5'd5, 1'b1, 32'h1234, 1'b1});
        issue(32'h40, 32'h1234, 32'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        // Loads of each size and sign
        doLoad(32'h44, 32'h103, 3'd0, 5'd7, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'h8);
        doLoad(32'h48, 32'h102, 3'd4, 5'd8, 32'h12F4_5678, 32'h0000_00F4, 4'h4);
        doLoad(32'h4C, 32'h102, 3'd1, 5'd9, 32'hBEEF_0000, 32'hFFFF_BEEF, 4'hC);
        doLoad(32'h50, 32'h102, 3'd5, 5'd10, 32'hBEEF_0000, 32'h0000_BEEF, 4'hC);
        doLoad(32'h54, 32'h104, 3'd2, 5'd11, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'hF);
        // SH with ready held low three cycles
        sb.push_back('{32'h58, 5'd3, 1'b0, 32'd0, 1'b0});
        issue(32'h58, 32'h102, 32'h0000_ABCD, 1'b0, 1'b1, 3'd1, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            @(negedge clk);
            chk("sh_req", {31'd0, dmem_req}, 32'd1);
            chk("sh_we", {31'd0, dmem_we}, 32'd1);
            chk("sh_addr", dmem_addr, 32'h100);
            chk("sh_be", {28'd0, dmem_be}, 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("sh_req_done", {31'd0, dmem_req}, 32'd0);
        chk("sh_stall_done", {31'd0, stall}, 32'd0);
        // Misaligned LW and illegal size code
        sb.push_back('{32'h5C, 5'd9, 1'b0, 32'd0, 1'b0});
        issue(32'h5C, 32'h101, 32'd0, 1'b1, 1'b0, 3'd2, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
        sb.push_back('{32'h60, 5'd12, 1'b0, 32'd0, 1'b0});
        issue(32'h60, 32'h100, 32'd0, 1'b0, 1'b1, 3'd3, 5'd12, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis3_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis3_req", {31'd0, dmem_req}, 32'd0);
        // Reset while waiting for read data, then a late rvalid
        issue(32'h64, 32'h200, 32'd0, 1'b1, 1'b0, 3'd2, 5'd10, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("rw_stall_wait", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_stall_rst", {31'd0, stall}, 32'd0);
        chk("rw_wb_rst", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_wb_late", {31'd0, wb_valid}, 32'd0);
        chk("rw_stall_late", {31'd0, stall}, 32'd0);
        // Flushed load starts nothing
        issue(32'h68, 32'h100, 32'd0, 1'b1, 1'b0, 3'd0, 5'd4, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_req", {31'd0, dmem_req}, 32'd0);
        chk("fl_stall", {31'd0, stall}, 32'd0);
        chk("fl_wb", {31'd0, wb_valid}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameters: XLEN, 32, datapath/address width; REG_ADDR_W, 5, register index width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execute result valid.
- ex_pc  in  XLEN  instruction PC.
- ex_alu_result  in  XLEN  ALU result / effective address.
- ex_store_data  in  XLEN  bypassed rs2.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_funct3  in  3  size/sign code.
- ex_rd_addr  in  REG_ADDR_W  destination register.
- ex_rd_we  in  1  destination write enable.
- flush  in  1  drop incoming instruction.
- stall  out  1  upstream hold request.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  XLEN  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_ready  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.
- wb_valid, wb_pc, wb_rd_addr, wb_rd_we, wb_rd_data  out  1/XLEN/REG_ADDR_W/1/XLEN  writeback pipe register.
- misaligned  out  1  one-cycle fault pulse.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT; stall = (state != IDLE).
REQ-004 In IDLE, ex_valid & !flush & !ex_mem_read & !ex_mem_write SHALL load the wb_* registers on the next edge with wb_rd_data = ex_alu_result (1-cycle latency).
REQ-005 In IDLE, an aligned memory op (ex_valid & !flush) SHALL latch address, size, sign, rd, pc and store data, set wb_valid=0 on the next edge, and enter REQ.
REQ-006 In REQ, dmem_req SHALL be 1 and addr/we/be/wdata SHALL stay stable until the cycle dmem_ready=1.
REQ-007 Store accepted in REQ SHALL write wb_valid=1, wb_rd_we=0 on the next edge and return to IDLE.
REQ-008 Load accepted in REQ SHALL enter WAIT; in WAIT, dmem_rvalid=1 SHALL write wb_valid=1, wb_rd_we=latched rd_we, wb_rd_data=extracted data, and return to IDLE.
REQ-009 Size = funct3[1:0] (0 byte, 1 half, 2 word); signed when funct3[2]=0; be = (1/3/F) << addr[1:0]; wdata = byte/half replicated across lanes; load data = rdata >> (8*addr[1:0]), then sign- or zero-extended.
REQ-010 Half with addr[0]=1, word with addr[1:0]!=0, or funct3[1:0]=3 SHALL issue no request, pulse misaligned for one cycle, write wb_valid=1 with wb_rd_we=0, and stay in IDLE.
REQ-011 While not in IDLE, wb_valid SHALL be 0 except on the completing edge; ex_* and flush SHALL be ignored.
REQ-012 dmem_rvalid in IDLE or REQ, and dmem_ready outside REQ, SHALL be ignored.
REQ-013 flush in IDLE SHALL force wb_valid=0 on the next edge and start no request.

Reset
REQ-014 rst SHALL immediately force state=IDLE and clear dmem_req, wb_valid, wb_rd_we, misaligned, and all wb data registers.
REQ-015 Reset mid-operation SHALL abandon the access; a late dmem_rvalid after reset SHALL produce no writeback.

Verification
REQ-016 ALU op, rd=5, alu=0x1234 -> next cycle wb_valid=1, wb_rd_data=0x1234, stall never asserted.
REQ-017 LB at 0x103, rdata=0x80FFFFFF, ready one cycle after capture, rvalid the following cycle -> wb_rd_data=0xFFFFFF80 three cycles after capture; stall high for 2 cycles.
REQ-018 SH at 0x102, data=0xABCD, ready held low 3 cycles -> dmem_req held 4 cycles, be=0xC, wdata=0xABCDABCD, dmem_addr=0x100 stable throughout.
REQ-019 LW at 0x101 -> misaligned one-cycle pulse, dmem_req never asserted, wb_valid=1, wb_rd_we=0.
REQ-020 Reset asserted in WAIT, then rvalid delivered -> state IDLE, wb_valid stays 0.
REQ-021 flush asserted with a valid load in IDLE -> no dmem_req, wb_valid=0.
